// File: rtl/gpu_mem_pkg.sv
// Shared constants, command kinds and arbiter state encodings for the GPU-to-SDRAM memory path.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package gpu_mem_pkg;

    localparam int SDRAM_ADDRESS_WIDTH = 30;

    // Byte offset of the HPS-reserved GPU window inside SDRAM.
    localparam logic [SDRAM_ADDRESS_WIDTH-1:0] SDRAM_BYTE_BASE = 30'h3E00_0000;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_kind_t;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_ISSUE = 1'b1;

    // Byte address (already zero-extended) to SDRAM word address.
    // The sum wraps modulo 2^30 and the two byte-lane bits are dropped.
    function automatic logic [SDRAM_ADDRESS_WIDTH-1:0] to_word_addr(
        input logic [SDRAM_ADDRESS_WIDTH-1:0] byte_addr,
        input logic [SDRAM_ADDRESS_WIDTH-1:0] base
    );
        logic [SDRAM_ADDRESS_WIDTH-1:0] sum;
        sum = byte_addr + base;
        return {2'b00, sum[SDRAM_ADDRESS_WIDTH-1:2]};
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of the per-port GPU Avalon-MM slaves and the single SDRAM Avalon-MM master.
// Latency: none (wires only).
// Backpressure: port_waitrequest toward clients, sdram_waitrequest from SDRAM.
// master modport: the arbiter; slave modport: the surrounding GPU array and SDRAM controller.
interface sdram_port_arbiter_if
    import gpu_mem_pkg::*;
#(
    parameter int NUM_PORTS         = 4,
    parameter int WORD_WIDTH        = 32,
    parameter int GPU_ADDRESS_WIDTH = 24
);

    logic [NUM_PORTS*GPU_ADDRESS_WIDTH-1:0] port_address;
    logic [NUM_PORTS-1:0]                   port_read;
    logic [NUM_PORTS-1:0]                   port_write;
    logic [NUM_PORTS*WORD_WIDTH-1:0]        port_writedata;
    logic [NUM_PORTS-1:0]                   port_waitrequest;
    logic [WORD_WIDTH-1:0]                  port_readdata;
    logic [NUM_PORTS-1:0]                   port_readdatavalid;

    logic [SDRAM_ADDRESS_WIDTH-1:0]         sdram_address;
    logic                                   sdram_read;
    logic                                   sdram_write;
    logic [WORD_WIDTH-1:0]                  sdram_writedata;
    logic                                   sdram_waitrequest;
    logic [WORD_WIDTH-1:0]                  sdram_readdata;
    logic                                   sdram_readdatavalid;

    modport master (
        input  port_address, port_read, port_write, port_writedata,
        output port_waitrequest, port_readdata, port_readdatavalid,
        output sdram_address, sdram_read, sdram_write, sdram_writedata,
        input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid
    );

    modport slave (
        output port_address, port_read, port_write, port_writedata,
        input  port_waitrequest, port_readdata, port_readdatavalid,
        input  sdram_address, sdram_read, sdram_write, sdram_writedata,
        output sdram_waitrequest, sdram_readdata, sdram_readdatavalid
    );

endinterface

// File: rtl/pending_read_fifo.sv
// Port-id FIFO remembering which client owns each outstanding SDRAM read.
// Latency: pushed entry visible at pop_dat one cycle after the push edge.
// Backpressure: push ignored when full (unless popping), pop ignored when empty.
// Ports: clock/reset, push/push_dat, pop/pop_dat (head), full, empty, count.
module pending_read_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter of NUM_PORTS GPU Avalon-MM masters onto one SDRAM master, with read-data routing.
// Latency: command on SDRAM bus 1 cycle after selection; read data to the port 1 cycle after sdram_readdatavalid.
// Backpressure: clients stall on port_waitrequest until their command is accepted by SDRAM; reads stall while the pending FIFO is full.
// Ports: clock, reset (sync, active high), bus (sdram_port_arbiter_if.master), error (sticky protocol error).
module sdram_port_arbiter #(
    parameter int                 NUM_PORTS         = 4,
    parameter int                 WORD_WIDTH        = 32,
    parameter int                 GPU_ADDRESS_WIDTH = 24,
    parameter logic [29:0]        SDRAM_BYTE_BASE   = gpu_mem_pkg::SDRAM_BYTE_BASE,
    parameter int                 MAX_PENDING       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    sdram_port_arbiter_if.master  bus,
    output logic                  error
);
    import gpu_mem_pkg::*;

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(MAX_PENDING);
    localparam int AB = SDRAM_ADDRESS_WIDTH;

    logic [0:0]            state;
    logic [PW-1:0]         rr;
    logic [PW-1:0]         cmd_port;
    cmd_kind_t             cmd_kind;
    logic [AB-1:0]         cmd_addr;
    logic [WORD_WIDTH-1:0] cmd_wdata;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  read_ok;
    logic                  sel_vld;
    logic [PW-1:0]         sel_idx;
    logic [PW-1:0]         cand;
    logic [NUM_PORTS-1:0]  elig;
    logic [AB-1:0]         p_addr  [NUM_PORTS];
    logic [WORD_WIDTH-1:0] p_wdata [NUM_PORTS];

    logic [PW-1:0]         fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW:0]           fifo_count;
    logic [AW:0]           cnt_next;

    assign accept   = ~reset & (state == ARB_ISSUE) & ~bus.sdram_waitrequest;
    assign push     = accept & (cmd_kind == CMD_READ);
    assign pop      = ~reset & bus.sdram_readdatavalid & ~fifo_empty;

    // A read may only be selected if its FIFO slot is guaranteed once it is
    // accepted, so occupancy is judged after this edge's push and pop.
    // A full FIFO can only gain room through this cycle's pop.
    assign cnt_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    assign read_ok  = fifo_full ? pop : (cnt_next < (AW+1)'(MAX_PENDING));

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            p_addr[i]  = AB'(bus.port_address[i*GPU_ADDRESS_WIDTH +: GPU_ADDRESS_WIDTH]);
            p_wdata[i] = bus.port_writedata[i*WORD_WIDTH +: WORD_WIDTH];
            // The port being accepted now still shows its request; it must not win again at this edge.
            elig[i]    = (bus.port_read[i] | bus.port_write[i])
                       & (~bus.port_read[i] | read_ok)
                       & ~(accept && (cmd_port == PW'(i)));
        end
    end

    // Round-robin search starting just after the last grant.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PW'((int'(rr) + k) % NUM_PORTS);
            if (!sel_vld && elig[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        bus.port_waitrequest = '1;
        if (accept) begin
            bus.port_waitrequest[cmd_port] = 1'b0;
        end
    end

    assign bus.sdram_read      = (state == ARB_ISSUE) && (cmd_kind == CMD_READ);
    assign bus.sdram_write     = (state == ARB_ISSUE) && (cmd_kind == CMD_WRITE);
    assign bus.sdram_address   = cmd_addr;
    assign bus.sdram_writedata = cmd_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state                  <= ARB_IDLE;
            rr                     <= PW'(NUM_PORTS - 1);
            cmd_port               <= '0;
            cmd_kind               <= CMD_READ;
            cmd_addr               <= '0;
            cmd_wdata              <= '0;
            error                  <= 1'b0;
            bus.port_readdata      <= '0;
            bus.port_readdatavalid <= '0;
        end else begin
            if ((state == ARB_IDLE) || accept) begin
                if (sel_vld) begin
                    state     <= ARB_ISSUE;
                    rr        <= sel_idx;
                    cmd_port  <= sel_idx;
                    // Read wins when a client asserts both; that is flagged.
                    cmd_kind  <= bus.port_read[sel_idx] ? CMD_READ : CMD_WRITE;
                    cmd_addr  <= to_word_addr(p_addr[sel_idx], SDRAM_BYTE_BASE);
                    cmd_wdata <= p_wdata[sel_idx];
                    if (bus.port_read[sel_idx] && bus.port_write[sel_idx]) begin
                        error <= 1'b1;
                    end
                end else begin
                    state <= ARB_IDLE;
                end
            end

            bus.port_readdatavalid <= '0;
            if (bus.sdram_readdatavalid) begin
                if (fifo_empty) begin
                    error <= 1'b1;
                end else begin
                    bus.port_readdatavalid <= NUM_PORTS'(1) << fifo_head;
                    bus.port_readdata      <= bus.sdram_readdata;
                end
            end
        end
    end

    pending_read_fifo #(
        .DEPTH (MAX_PENDING),
        .WIDTH (PW)
    ) u_pending (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (cmd_port),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: address-translation vector table plus multi-cycle sequences.
// Latency: not applicable.
// Backpressure: sdram_waitrequest driven directly by the sequences.
module tb_sdram_port_arbiter;
    import gpu_mem_pkg::*;

    localparam int NP = 4;
    localparam int WW = 32;
    localparam int GW = 24;
    localparam int MP = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic error;
    int   n_checks = 0;
    int   n_fail   = 0;

    sdram_port_arbiter_if #(.NUM_PORTS(NP), .WORD_WIDTH(WW), .GPU_ADDRESS_WIDTH(GW)) bus ();

    sdram_port_arbiter #(
        .NUM_PORTS         (NP),
        .WORD_WIDTH        (WW),
        .GPU_ADDRESS_WIDTH (GW),
        .SDRAM_BYTE_BASE   (30'h3E00_0000),
        .MAX_PENDING       (MP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master),
        .error (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          port;
        logic [23:0] addr;
        logic [29:0] exp_addr;
        logic [31:0] rdata;
        logic [3:0]  exp_strobe;
        logic [3:0]  exp_pw;
    } addr_vec_t;

    addr_vec_t  vecs [6];
    logic [3:0] rr_pw [5];
    logic [31:0] rr_wd [5];

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_addr(input int p, input logic [23:0] a);
        bus.port_address[p*GW +: GW] = a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Single uncontended read, accepted immediately; leaves one FIFO entry.
    task automatic do_read(input int p, input logic [23:0] a);
        set_addr(p, a);
        bus.port_read[p] = 1'b1;
        step();
        bus.port_read[p] = 1'b0;
        step();
    endtask

    initial begin
        vecs[0] = '{0, 24'h000000, 30'h0F80_0000, 32'h1111_0000, 4'b0001, 4'b1110};
        vecs[1] = '{1, 24'h000003, 30'h0F80_0000, 32'h2222_0001, 4'b0010, 4'b1101};
        vecs[2] = '{2, 24'h000010, 30'h0F80_0004, 32'h3333_0002, 4'b0100, 4'b1011};
        vecs[3] = '{3, 24'h123456, 30'h0F84_8D15, 32'h4444_0003, 4'b1000, 4'b0111};
        vecs[4] = '{1, 24'hFFFFFF, 30'h0FBF_FFFF, 32'h5555_0004, 4'b0010, 4'b1101};
        vecs[5] = '{0, 24'h800001, 30'h0FA0_0000, 32'h6666_0005, 4'b0001, 4'b1110};
        rr_pw = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        rr_wd = '{32'h1000_0000, 32'h1000_0011, 32'h1000_0022, 32'h1000_0033, 32'h1000_0000};

        bus.port_address        = '0;
        bus.port_read           = '0;
        bus.port_write          = '0;
        bus.port_writedata      = '0;
        bus.sdram_waitrequest   = 1'b0;
        bus.sdram_readdata      = '0;
        bus.sdram_readdatavalid = 1'b0;

        // Reset state (reset still asserted)
        step();
        step();
        check("rst_pw",    bus.port_waitrequest, 4'hF);
        check("rst_rd",    bus.sdram_read, 1'b0);
        check("rst_wr",    bus.sdram_write, 1'b0);
        check("rst_addr",  bus.sdram_address, 30'h0);
        check("rst_wdata", bus.sdram_writedata, 32'h0);
        check("rst_rdv",   bus.port_readdatavalid, 4'h0);
        check("rst_rdata", bus.port_readdata, 32'h0);
        check("rst_err",   error, 1'b0);
        reset = 1'b0;
        step();

        // Single read with two stall cycles
        set_addr(0, 24'h000010);
        bus.port_read[0] = 1'b1;
        bus.sdram_waitrequest = 1'b1;
        step();
        check("t1_addr0", bus.sdram_address, 30'h0F80_0004);
        check("t1_read",  bus.sdram_read, 1'b1);
        check("t1_pw0",   bus.port_waitrequest, 4'hF);
        step();
        check("t1_addr1", bus.sdram_address, 30'h0F80_0004);
        check("t1_pw1",   bus.port_waitrequest, 4'hF);
        bus.sdram_waitrequest = 1'b0;
        #1;
        check("t1_addr2",  bus.sdram_address, 30'h0F80_0004);
        check("t1_pw_acc", bus.port_waitrequest, 4'hE);
        step();
        bus.port_read[0] = 1'b0;
        check("t1_rd_off", bus.sdram_read, 1'b0);
        check("t1_pw_idl", bus.port_waitrequest, 4'hF);
        step();
        step();
        bus.sdram_readdatavalid = 1'b1;
        bus.sdram_readdata = 32'hDEAD_BEEF;
        step();
        bus.sdram_readdatavalid = 1'b0;
        check("t1_rdv",   bus.port_readdatavalid, 4'b0001);
        check("t1_rdata", bus.port_readdata, 32'hDEAD_BEEF);
        step();
        check("t1_rdv_off", bus.port_readdatavalid, 4'b0000);

        // Address translation / routing table
        for (int v = 0; v < 6; v++) begin
            set_addr(vecs[v].port, vecs[v].addr);
            bus.port_read[vecs[v].port] = 1'b1;
            step();
            check("vec_addr", bus.sdram_address, vecs[v].exp_addr);
            check("vec_read", bus.sdram_read, 1'b1);
            check("vec_pw",   bus.port_waitrequest, vecs[v].exp_pw);
            bus.port_read[vecs[v].port] = 1'b0;
            step();
            bus.sdram_readdatavalid = 1'b1;
            bus.sdram_readdata = vecs[v].rdata;
            step();
            bus.sdram_readdatavalid = 1'b0;
            check("vec_rdv",   bus.port_readdatavalid, vecs[v].exp_strobe);
            check("vec_rdata", bus.port_readdata, vecs[v].rdata);
        end

        // Round-robin with four continuous writers
        do_reset();
        for (int p = 0; p < NP; p++) begin
            bus.port_writedata[p*WW +: WW] = rr_wd[p];
        end
        bus.port_write = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_write", bus.sdram_write, 1'b1);
            check("rr_pw",    bus.port_waitrequest, rr_pw[k]);
            check("rr_wdata", bus.sdram_writedata, rr_wd[k]);
        end
        bus.port_write = 4'h0;
        step();
        check("rr_idle", bus.sdram_write, 1'b0);

        // Return routing in FIFO order: ports 2, 0, 3
        do_read(2, 24'h000100);
        do_read(0, 24'h000200);
        do_read(3, 24'h000300);
        bus.sdram_readdatavalid = 1'b1;
        bus.sdram_readdata = 32'hAAAA_0002;
        step();
        check("ord_a_rdv",  bus.port_readdatavalid, 4'b0100);
        check("ord_a_data", bus.port_readdata, 32'hAAAA_0002);
        bus.sdram_readdata = 32'hBBBB_0000;
        step();
        check("ord_b_rdv",  bus.port_readdatavalid, 4'b0001);
        check("ord_b_data", bus.port_readdata, 32'hBBBB_0000);
        bus.sdram_readdata = 32'hCCCC_0003;
        step();
        check("ord_c_rdv",  bus.port_readdatavalid, 4'b1000);
        check("ord_c_data", bus.port_readdata, 32'hCCCC_0003);
        bus.sdram_readdatavalid = 1'b0;
        step();
        check("ord_rdv_off", bus.port_readdatavalid, 4'b0000);
        check("ord_err",     error, 1'b0);

        // FIFO full: reads stall, writes still flow
        for (int i = 0; i < MP; i++) begin
            do_read(0, 24'(i * 4));
        end
        set_addr(1, 24'h000040);
        bus.port_read[1] = 1'b1;
        bus.port_write[2] = 1'b1;
        bus.port_writedata[2*WW +: WW] = 32'hCAFE_0002;
        step();
        check("full_wr",    bus.sdram_write, 1'b1);
        check("full_rd",    bus.sdram_read, 1'b0);
        check("full_pw",    bus.port_waitrequest, 4'b1011);
        check("full_wdata", bus.sdram_writedata, 32'hCAFE_0002);
        bus.port_write[2] = 1'b0;
        step();
        check("full_stall_rd", bus.sdram_read, 1'b0);
        check("full_stall_wr", bus.sdram_write, 1'b0);
        step();
        check("full_stall2", bus.sdram_read, 1'b0);
        bus.sdram_readdatavalid = 1'b1;
        bus.sdram_readdata = 32'h0000_0055;
        step();
        bus.sdram_readdatavalid = 1'b0;
        check("full_resume_rd", bus.sdram_read, 1'b1);
        check("full_resume_pw", bus.port_waitrequest, 4'b1101);
        check("full_pop_rdv",   bus.port_readdatavalid, 4'b0001);
        bus.port_read[1] = 1'b0;
        step();
        bus.sdram_readdatavalid = 1'b1;
        for (int i = 0; i < MP; i++) begin
            bus.sdram_readdata = 32'(i);
            step();
            check("full_drain", bus.port_readdatavalid, (i == MP - 1) ? 4'b0010 : 4'b0001);
        end
        bus.sdram_readdatavalid = 1'b0;
        step();

        // Errors
        bus.sdram_readdatavalid = 1'b1;
        step();
        bus.sdram_readdatavalid = 1'b0;
        check("err_empty",     error, 1'b1);
        check("err_empty_rdv", bus.port_readdatavalid, 4'b0000);
        do_reset();
        check("err_clr1", error, 1'b0);
        set_addr(1, 24'h000008);
        bus.port_read[1] = 1'b1;
        bus.port_write[1] = 1'b1;
        step();
        check("rw_read",  bus.sdram_read, 1'b1);
        check("rw_write", bus.sdram_write, 1'b0);
        check("rw_err",   error, 1'b1);
        bus.port_read[1] = 1'b0;
        bus.port_write[1] = 1'b0;
        step();
        bus.sdram_readdatavalid = 1'b1;
        step();
        bus.sdram_readdatavalid = 1'b0;
        check("rw_rdv", bus.port_readdatavalid, 4'b0010);
        do_reset();
        check("err_clr2", error, 1'b0);

        // Reset while a read is stalled in ISSUE, with one read already pending
        do_read(3, 24'h000020);
        set_addr(0, 24'h000030);
        bus.port_read[0] = 1'b1;
        bus.sdram_waitrequest = 1'b1;
        step();
        check("mid_rd", bus.sdram_read, 1'b1);
        reset = 1'b1;
        step();
        check("mid_rd_drop", bus.sdram_read, 1'b0);
        check("mid_pw",      bus.port_waitrequest, 4'hF);
        bus.port_read[0] = 1'b0;
        bus.sdram_waitrequest = 1'b0;
        reset = 1'b0;
        step();
        check("mid_err0", error, 1'b0);
        bus.sdram_readdatavalid = 1'b1;
        step();
        bus.sdram_readdatavalid = 1'b0;
        check("mid_late_err", error, 1'b1);
        check("mid_late_rdv", bus.port_readdatavalid, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Multi-client successor to the single-GPU SDRAM hookup. It arbitrates NUM_PORTS GPU-side Avalon-MM masters onto one SDRAM Avalon-MM master and converts each port's GPU byte address into the HPS-reserved SDRAM word window. A pending-read FIFO routes read data back to the originating port. It sits between the GPU core array and the top-level sdram_* pins.

Parameters:
NUM_PORTS, 4, number of GPU-side client ports (2..8)
WORD_WIDTH, 32, data width
GPU_ADDRESS_WIDTH, 24, client byte-address width
SDRAM_BYTE_BASE, 30'h3E000000, byte offset of the GPU window in SDRAM
MAX_PENDING, 8, outstanding reads supported (power of two)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
port_address  in  NUM_PORTS*GPU_ADDRESS_WIDTH  per-port byte address, port i at slice i
port_read  in  NUM_PORTS  per-port read request
port_write  in  NUM_PORTS  per-port write request
port_writedata  in  NUM_PORTS*WORD_WIDTH  per-port write data
port_waitrequest  out  NUM_PORTS  per-port stall
port_readdata  out  WORD_WIDTH  shared read-data bus
port_readdatavalid  out  NUM_PORTS  one-hot read-data strobe
sdram_address  out  30  word address = (port byte addr + SDRAM_BYTE_BASE) >> 2
sdram_read  out  1  master read
sdram_write  out  1  master write
sdram_writedata  out  WORD_WIDTH  master write data
sdram_waitrequest  in  1  slave stall
sdram_readdata  in  WORD_WIDTH  slave read data
sdram_readdatavalid  in  1  slave read-data strobe
error  out  1  sticky protocol-error flag

Behaviour:
- Reset values: sdram_read=0, sdram_write=0, sdram_address=0, sdram_writedata=0, port_readdatavalid=0, port_readdata=0, error=0, FIFO empty, rr pointer=NUM_PORTS-1, FSM=IDLE. port_waitrequest is all ones during reset.
- Requester: port i is a requester when port_read[i] or port_write[i] is set. A requester whose command would be a read is ineligible while the FIFO is full. Writes stay eligible.
- Selection: round-robin. Search starts at rr+1 and wraps modulo NUM_PORTS. On selection, rr takes the granted index.
- FSM IDLE: on a clock edge with at least one eligible requester, latch grant index, kind, translated address and writedata into the command register, then go to ISSUE. The master outputs are driven from the command register, so they assert 1 cycle after selection.
- FSM ISSUE: hold all master outputs stable while sdram_waitrequest=1.
- Accept cycle: ISSUE and sdram_waitrequest=0.
  - port_waitrequest[grant]=0 combinationally in that cycle. All other ports stay at 1.
  - A read pushes the grant index into the FIFO at that edge.
  - At the same edge, select the next eligible requester, excluding the port just accepted, and stay in ISSUE. With no such requester, go to IDLE and deassert sdram_read/sdram_write.
  - Sustained throughput is 1 command per cycle with multiple requesters.
- Address arithmetic: zero-extend the port address to 30 bits, add SDRAM_BYTE_BASE modulo 2^30, then shift right by 2. The low 2 bits of the port address are discarded.
- Read return:
  - On sdram_readdatavalid, pop the FIFO head h.
  - Register the outputs: port_readdata=sdram_readdata and port_readdatavalid=one-hot(h), valid the next cycle.
  - A readdatavalid arriving with the FIFO empty is dropped and sets error.
  - A simultaneous push and pop in one cycle is legal and keeps the count unchanged.
- Read and write both asserted on one port: treated as a read, and error is set.
- Reset mid-operation: the command is abandoned, master outputs drop at the reset edge, and pending reads are discarded. Late responses then hit the empty-FIFO rule.
- error clears only on reset.

Decomposition:
- Shared package gpu_mem_pkg holds SDRAM_BYTE_BASE, the SDRAM_ADDRESS_WIDTH=30 constant, the command-kind enum {CMD_READ, CMD_WRITE} and the FSM state enum {ARB_IDLE, ARB_ISSUE}.
- One sub-module, pending_read_fifo, holds the port-id FIFO. It has depth MAX_PENDING and width clog2(NUM_PORTS), plus full/empty flags and simultaneous push/pop support.

Test Plan:
1. Single read: port 0 read at addr 0x000010, waitrequest held 2 cycles, readdata 0xDEADBEEF returned 3 cycles later.
   - sdram_address=0x0F800004, held stable for 3 cycles.
   - port_waitrequest[0] low only in the accept cycle.
   - port_readdatavalid=4'b0001 with data 0xDEADBEEF.
2. Round-robin: all 4 ports issue writes continuously, waitrequest=0.
   - Grant order is 0,1,2,3,0, one accept per cycle.
   - Each port's writedata appears on sdram_writedata in its own slot.
3. Out-of-order return routing: ports 2, 0, 3 each read, then three responses A, B, C arrive.
   - A goes to port 2, B to port 0, C to port 3, each one-hot in FIFO order.
4. FIFO full: MAX_PENDING reads outstanding with no responses.
   - Further reads stall and a write from another port is still accepted.
   - After one response, the next read issues.
5. Errors:
   - readdatavalid with nothing pending sets error=1 and asserts no port strobe.
   - Read+write asserted together on port 1 is issued as a read and sets error.
   - Reset clears error to 0.
6. Reset mid-ISSUE while waitrequest=1: sdram_read drops at the reset edge, all port_waitrequest stay high, and the FIFO is empty afterwards.
